// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPARE = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    // One-hot result ordering is {a_greater_b, a_equal_b, b_greater_a}.
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/comparator_bit_cell.sv
// Combinational 1-bit magnitude comparator implemented as a 4:1 mux on {a,b}.
module comparator_bit_cell
    import cmp_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    logic [2:0] res;

    always_comb begin
        res = RES_NONE;
        unique case ({a, b})
            2'b00:   res = RES_EQ;
            2'b01:   res = RES_LT;
            2'b10:   res = RES_GT;
            2'b11:   res = RES_EQ;
            default: res = RES_NONE;
        endcase
    end

    assign gt = res[2];
    assign eq = res[1];
    assign lt = res[0];

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Multi-cycle WIDTH-bit magnitude comparator: operands shift MSB-first through
// one shared 1-bit comparator cell, producing a registered one-hot result.
module serial_comparator_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             a_greater_b,
    output logic             a_equal_b,
    output logic             b_greater_a
);

    localparam int unsigned CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       diff_res_q, diff_res_d;
    logic [2:0]       res_q, res_d;

    logic             bit_gt, bit_eq, bit_lt;
    logic [2:0]       cell_res;

    comparator_bit_cell u_cell (
        .a  (a_sh_q[WIDTH-1]),
        .b  (b_sh_q[WIDTH-1]),
        .gt (bit_gt),
        .eq (bit_eq),
        .lt (bit_lt)
    );

    assign cell_res = {bit_gt, bit_eq, bit_lt};

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        cnt_d      = cnt_q;
        diff_res_d = diff_res_q;
        res_d      = res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d     = a_in;
                    b_sh_d     = b_in;
                    cnt_d      = CW'(WIDTH - 1);
                    diff_res_d = RES_NONE;
                    state_d    = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    a_sh_d = a_sh_q << 1;
                    b_sh_d = b_sh_q << 1;
                    cnt_d  = cnt_q - 1'b1;
                    // Sticky first-difference record; later bits cannot override it.
                    if (diff_res_q == RES_NONE && !bit_eq) begin
                        diff_res_d = cell_res;
                    end
                    if (EARLY_EXIT && !bit_eq) begin
                        res_d   = cell_res;
                        state_d = ST_DONE;
                    end else if (cnt_q == '0) begin
                        res_d   = (diff_res_q != RES_NONE) ? diff_res_q : cell_res;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            cnt_q      <= '0;
            diff_res_q <= RES_NONE;
            res_q      <= RES_NONE;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            cnt_q      <= cnt_d;
            diff_res_q <= diff_res_d;
            res_q      <= res_d;
        end
    end

    assign busy        = (state_q == ST_COMPARE) || (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign a_greater_b = res_q[2];
    assign a_equal_b   = res_q[1];
    assign b_greater_a = res_q[0];

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed bench for serial_comparator_ctrl: runs EARLY_EXIT=1 and EARLY_EXIT=0
// instances side by side against an arithmetic reference model.
module tb_serial_comparator_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;

    logic [1:0]   busy, done, agb, aeb, bga;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    serial_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_in(a_in), .b_in(b_in),
        .busy(busy[0]), .done(done[0]),
        .a_greater_b(agb[0]), .a_equal_b(aeb[0]), .b_greater_a(bga[0])
    );

    serial_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_in(a_in), .b_in(b_in),
        .busy(busy[1]), .done(done[1]),
        .a_greater_b(agb[1]), .a_equal_b(aeb[1]), .b_greater_a(bga[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags_of(input int i);
        return {agb[i], aeb[i], bga[i]};
    endfunction

    // Reference: result by arithmetic, latency from MSB-first index of first difference.
    function automatic logic [2:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
        if (a == b || !ee) return W;
        for (int k = 0; k < W; k++) begin
            if (a[W-1-k] != b[W-1-k]) return k + 1;
        end
        return W;
    endfunction

    logic [1:0] m_cmp, m_done;
    int         m_left [2];
    logic [2:0] m_pend [2];
    logic [2:0] m_flags[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_cmp[i]   <= 1'b0;
                m_done[i]  <= 1'b0;
                m_left[i]  <= 0;
                m_pend[i]  <= 3'b000;
                m_flags[i] <= 3'b000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end else if (m_cmp[i]) begin
                    if (abort) begin
                        m_cmp[i] <= 1'b0;
                    end else if (m_left[i] == 1) begin
                        m_cmp[i]   <= 1'b0;
                        m_done[i]  <= 1'b1;
                        m_flags[i] <= m_pend[i];
                    end else begin
                        m_left[i] <= m_left[i] - 1;
                    end
                end else if (start) begin
                    m_cmp[i]  <= 1'b1;
                    m_left[i] <= exp_lat(a_in, b_in, i == 0);
                    m_pend[i] <= exp_res(a_in, b_in);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cycle_dut%0d {busy,done,gt,eq,lt}", i),
                    {busy[i], done[i], flags_of(i)},
                    {m_cmp[i] | m_done[i], m_done[i], m_flags[i]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy != 2'b00) && n < 40) begin
            step();
            n++;
        end
        chk("wait_idle timeout", int'(busy), 0);
    endtask

    // Edge 0 accepts start; optional glitch keeps start high with inverted operands for edge 1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch,
                          input int exp_l0, input int exp_l1, input logic [2:0] exp_f);
        int lat[2];
        logic [2:0] fl[2];
        lat[0] = -1;
        lat[1] = -1;
        fl[0]  = 3'b000;
        fl[1]  = 3'b000;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        chk("busy after accept", int'(busy), 3);
        start = glitch;
        if (glitch) begin
            a_in = ~a;
            b_in = ~b;
        end
        for (int e = 1; e <= 20 && (lat[0] < 0 || lat[1] < 0); e++) begin
            step();
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (done[i] && lat[i] < 0) begin
                    lat[i] = e;
                    fl[i]  = flags_of(i);
                end
            end
        end
        chk($sformatf("latency_ee a=%0h b=%0h", a, b), lat[0], exp_l0);
        chk($sformatf("latency_full a=%0h b=%0h", a, b), lat[1], exp_l1);
        chk($sformatf("flags_ee a=%0h b=%0h", a, b), int'(fl[0]), int'(exp_f));
        chk($sformatf("flags_full a=%0h b=%0h", a, b), int'(fl[1]), int'(exp_f));
        step();
        chk("busy low after done", int'(busy), 0);
    endtask

    initial begin
        int  cnt[2];
        bit  seen_done;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk("reset dut0", {busy[0], done[0], flags_of(0)}, 0);
        chk("reset dut1", {busy[1], done[1], flags_of(1)}, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        run_op(8'hA5, 8'hA5, 1'b0, 8, 8, 3'b010);
        run_op(8'h80, 8'h7F, 1'b0, 1, 8, 3'b100);
        run_op(8'h3C, 8'h34, 1'b0, 5, 8, 3'b100);
        run_op(8'h12, 8'h13, 1'b0, 8, 8, 3'b001);
        run_op(8'h00, 8'hFF, 1'b1, 1, 8, 3'b001);

        a_in  = 8'h5A;
        b_in  = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("busy after abort", int'(busy), 0);
        seen_done = 1'b0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (done != 2'b00) seen_done = 1'b1;
        end
        chk("no done after abort", int'(seen_done), 0);
        chk("flags_ee kept after abort", int'(flags_of(0)), 3'b001);
        chk("flags_full kept after abort", int'(flags_of(1)), 3'b001);

        cnt[0] = 0;
        cnt[1] = 0;
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        step();
        for (int e = 1; e <= 36; e++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (done[i]) cnt[i]++;
            end
        end
        start = 1'b0;
        chk("b2b done count ee", cnt[0], 4);
        chk("b2b done count full", cnt[1], 3);
        chk("b2b flags_ee", int'(flags_of(0)), 3'b001);
        wait_idle();

        a_in  = 8'h3C;
        b_in  = 8'h3C;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset dut0", {busy[0], done[0], flags_of(0)}, 0);
        chk("async reset dut1", {busy[1], done[1], flags_of(1)}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_op(8'h80, 8'h7F, 1'b0, 1, 8, 3'b100);

        wait_idle();
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule
